// File: rtl/jtag_dtm_v2_if.sv
// jtag_dtm_v2_if: DMI request/response handshake bundle between the DTM and
// the debug module. Signal directions in the names are as seen from the DTM;
// the master modport is the DTM side and the slave modport is the DM side.
interface jtag_dtm_v2_if #(
  parameter int DMI_ADDR_BITS = 7
);
  localparam int DmiW = DMI_ADDR_BITS + 34;

  logic            dmi_req_o;
  logic [DmiW-1:0] dmi_req_data_o;
  logic            dmi_req_ack_i;
  logic            dmi_resp_i;
  logic [DmiW-1:0] dmi_resp_data_i;
  logic            dmi_resp_ack_o;

  modport master (
    output dmi_req_o, dmi_req_data_o, dmi_resp_ack_o,
    input  dmi_req_ack_i, dmi_resp_i, dmi_resp_data_i
  );

  modport slave (
    input  dmi_req_o, dmi_req_data_o, dmi_resp_ack_o,
    output dmi_req_ack_i, dmi_resp_i, dmi_resp_data_i
  );
endinterface

// File: rtl/jtag_dtm_v2.sv
// jtag_dtm_v2: JTAG debug transport module. A 1149.1 TAP with IDCODE, DTMCS,
// DMI and BYPASS data registers, bridging DMI scans onto a 4-phase
// request/response handshake that may live in another clock domain.
// Optional feature: define JTAG_DTM_HARDRESET_EN to honour dtmcs.dmihardreset.
module jtag_dtm_v2 #(
  parameter int          DMI_ADDR_BITS = 7,
  parameter int          IR_BITS       = 5,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1e200a6f,
  parameter int          IDLE_CYCLES   = 3,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic          jtag_tck_i,
  input  logic          rst_n,
  input  logic          jtag_tms_i,
  input  logic          jtag_tdi_i,
  output logic          jtag_tdo_o,
  output logic          jtag_tdo_oe_o,
  jtag_dtm_v2_if.master dmi,
  output logic          dm_hardreset_o
);
  localparam int DmiW = DMI_ADDR_BITS + 34;
  localparam int LenW = $clog2(DmiW);
  localparam logic [IR_BITS-1:0] IrIdcode   = IR_BITS'(1);
  localparam logic [IR_BITS-1:0] IrDtmcs    = IR_BITS'(16);
  localparam logic [IR_BITS-1:0] IrDmi      = IR_BITS'(17);
  localparam logic [2:0]         IdleField  = 3'(IDLE_CYCLES);
  localparam logic [5:0]         AbitsField = 6'(DMI_ADDR_BITS);

  typedef enum logic [3:0] {
    TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr,
    PauseDr, Exit2Dr, UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir,
    PauseIr, Exit2Ir, UpdateIr
  } tapState_e;

  typedef enum logic [1:0] {DmiIdle, DmiReq, DmiWaitAckLow, DmiWaitResp} dmiState_e;

  tapState_e          tapState_q, tapState_d;
  dmiState_e          dmiState_q, dmiState_d;
  logic [IR_BITS-1:0] irShift_q, irShift_d, ir_q;
  logic [DmiW-1:0]    dr_q, dr_d;
  logic [DmiW-1:0]    reqData_q, reqData_d, respData_q, respData_d;
  logic [LenW-1:0]    drLast;
  logic [SYNC_STAGES-1:0] ackSync_q, respSync_q;
  logic tdo_q, tdoOe_q;
  logic respAck_q, respAck_d;
  logic stickyBusy_q, stickyBusy_d, stickyErr_q, stickyErr_d;
  logic ackSynced, respSynced, dmiCapBusy, dmiUpdate, dtmcsUpdate;
  logic [1:0] dmiStat;

  assign ackSynced   = ackSync_q[SYNC_STAGES-1];
  assign respSynced  = respSync_q[SYNC_STAGES-1];
  assign dmiCapBusy  = (tapState_q == CaptureDr) && (ir_q == IrDmi) &&
                       (stickyBusy_q || dmiState_q != DmiIdle);
  assign dmiUpdate   = (tapState_q == UpdateDr) && (ir_q == IrDmi);
  assign dtmcsUpdate = (tapState_q == UpdateDr) && (ir_q == IrDtmcs);
  assign dmiStat     = stickyBusy_q ? 2'b11 : (stickyErr_q ? 2'b10 : 2'b00);

  // TAP controller state, IR shifter and DR shifter all advance on rising TCK.
  always_ff @(posedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      tapState_q <= TestLogicReset;
      irShift_q  <= '0;
      dr_q       <= '0;
    end else begin
      tapState_q <= tapState_d;
      irShift_q  <= irShift_d;
      dr_q       <= dr_d;
    end
  end

  // Standard 1149.1 TAP transition table driven by TMS.
  always_comb begin
    tapState_d = tapState_q;
    unique case (tapState_q)
      TestLogicReset: tapState_d = jtag_tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    tapState_d = jtag_tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   tapState_d = jtag_tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      tapState_d = jtag_tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        tapState_d = jtag_tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        tapState_d = jtag_tms_i ? UpdateDr       : PauseDr;
      PauseDr:        tapState_d = jtag_tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        tapState_d = jtag_tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       tapState_d = jtag_tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   tapState_d = jtag_tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      tapState_d = jtag_tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        tapState_d = jtag_tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        tapState_d = jtag_tms_i ? UpdateIr       : PauseIr;
      PauseIr:        tapState_d = jtag_tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        tapState_d = jtag_tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       tapState_d = jtag_tms_i ? SelectDrScan   : RunTestIdle;
    endcase
  end

  // IR shifter: capture the fixed ...01 pattern, then shift LSB first.
  always_comb begin
    irShift_d = irShift_q;
    if (tapState_q == CaptureIr) begin
      irShift_d = IR_BITS'(1);
    end else if (tapState_q == ShiftIr) begin
      irShift_d = {jtag_tdi_i, irShift_q[IR_BITS-1:1]};
    end
  end

  // DR shifter: capture per selected register, then shift with TDI entering
  // at the top bit of that register's length.
  always_comb begin
    dr_d   = dr_q;
    drLast = LenW'(0);
    if (ir_q == IrDmi) begin
      drLast = LenW'(DmiW - 1);
    end else if (ir_q == IrIdcode || ir_q == IrDtmcs) begin
      drLast = LenW'(31);
    end
    if (tapState_q == CaptureDr) begin
      if (ir_q == IrIdcode) begin
        dr_d = DmiW'(IDCODE_VALUE | 32'h1);
      end else if (ir_q == IrDtmcs) begin
        dr_d = DmiW'({14'b0, 2'b00, 1'b0, IdleField, dmiStat, AbitsField, 4'h1});
      end else if (ir_q == IrDmi) begin
        if (dmiCapBusy) begin
          dr_d = DmiW'(2'b11);
        end else if (stickyErr_q) begin
          dr_d = DmiW'(2'b10);
        end else begin
          dr_d = respData_q;
        end
      end else begin
        dr_d = '0;
      end
    end else if (tapState_q == ShiftDr) begin
      dr_d         = dr_q >> 1;
      dr_d[drLast] = jtag_tdi_i;
    end
  end

  // Instruction register updates on falling TCK so it is stable for the next rising edge.
  always_ff @(negedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= IrIdcode;
    end else if (tapState_q == TestLogicReset) begin
      ir_q <= IrIdcode;
    end else if (tapState_q == UpdateIr) begin
      ir_q <= irShift_q;
    end
  end

  // TDO launches on falling TCK, enabled only while a shift state is active.
  always_ff @(negedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      tdo_q   <= 1'b0;
      tdoOe_q <= 1'b0;
    end else if (tapState_q == ShiftIr) begin
      tdo_q   <= irShift_q[0];
      tdoOe_q <= 1'b1;
    end else if (tapState_q == ShiftDr) begin
      tdo_q   <= dr_q[0];
      tdoOe_q <= 1'b1;
    end else begin
      tdo_q   <= 1'b0;
      tdoOe_q <= 1'b0;
    end
  end

  // Bring the DM-side handshake inputs into the TCK domain.
  always_ff @(posedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      ackSync_q  <= '0;
      respSync_q <= '0;
    end else begin
      ackSync_q  <= {ackSync_q[SYNC_STAGES-2:0], dmi.dmi_req_ack_i};
      respSync_q <= {respSync_q[SYNC_STAGES-2:0], dmi.dmi_resp_i};
    end
  end

`ifdef JTAG_DTM_HARDRESET_EN
  logic hardReset_q, hardReset_d;
  assign dm_hardreset_o = hardReset_q;
`else
  assign dm_hardreset_o = 1'b0;
`endif

  // DMI transaction state, sticky flags and stored response.
  always_ff @(posedge jtag_tck_i or negedge rst_n) begin
    if (!rst_n) begin
      dmiState_q   <= DmiIdle;
      reqData_q    <= '0;
      respData_q   <= '0;
      respAck_q    <= 1'b0;
      stickyBusy_q <= 1'b0;
      stickyErr_q  <= 1'b0;
`ifdef JTAG_DTM_HARDRESET_EN
      hardReset_q  <= 1'b0;
`endif
    end else begin
      dmiState_q   <= dmiState_d;
      reqData_q    <= reqData_d;
      respData_q   <= respData_d;
      respAck_q    <= respAck_d;
      stickyBusy_q <= stickyBusy_d;
      stickyErr_q  <= stickyErr_d;
`ifdef JTAG_DTM_HARDRESET_EN
      hardReset_q  <= hardReset_d;
`endif
    end
  end

  // Request FSM and response handshake. A response is only accepted outside
  // the request phases so it can never be acknowledged and then lost; when
  // idle (e.g. after a reset) it is acknowledged but not stored.
  always_comb begin
    dmiState_d   = dmiState_q;
    reqData_d    = reqData_q;
    respData_d   = respData_q;
    respAck_d    = respAck_q;
    stickyBusy_d = stickyBusy_q;
    stickyErr_d  = stickyErr_q;
`ifdef JTAG_DTM_HARDRESET_EN
    hardReset_d  = 1'b0;
`endif
    if (!respSynced) begin
      respAck_d = 1'b0;
    end else if (!respAck_q && (dmiState_q == DmiWaitResp || dmiState_q == DmiIdle)) begin
      respAck_d = 1'b1;
      if (dmiState_q == DmiWaitResp) begin
        respData_d = dmi.dmi_resp_data_i;
        dmiState_d = DmiIdle;
        if (dmi.dmi_resp_data_i[1]) begin
          stickyErr_d = 1'b1;
        end
      end
    end
    case (dmiState_q)
      DmiReq:        if (ackSynced)  dmiState_d = DmiWaitAckLow;
      DmiWaitAckLow: if (!ackSynced) dmiState_d = DmiWaitResp;
      default:       ;
    endcase
    if (dmiCapBusy) begin
      stickyBusy_d = 1'b1;
    end
    if (dtmcsUpdate && dr_q[16]) begin
      stickyBusy_d = 1'b0;
      stickyErr_d  = 1'b0;
    end
    if (dmiUpdate && dmiState_q == DmiIdle && !stickyBusy_q && !stickyErr_q &&
        (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
      reqData_d  = dr_q;
      dmiState_d = DmiReq;
    end
`ifdef JTAG_DTM_HARDRESET_EN
    if (dtmcsUpdate && dr_q[17]) begin
      stickyBusy_d = 1'b0;
      stickyErr_d  = 1'b0;
      dmiState_d   = DmiIdle;
      hardReset_d  = 1'b1;
    end
`endif
  end

  assign dmi.dmi_req_o      = (dmiState_q == DmiReq);
  assign dmi.dmi_req_data_o = reqData_q;
  assign dmi.dmi_resp_ack_o = respAck_q;
  assign jtag_tdo_o         = tdo_q;
  assign jtag_tdo_oe_o      = tdoOe_q;
endmodule

// File: doc/jtag_dtm_v2.md
JTAG_DTM_V2 -- requirements
Module: jtag_dtm_v2

Interface
REQ-001 SHALL have parameter DMI_ADDR_BITS, default 7, DMI address width (1..63).
REQ-002 SHALL have parameter IR_BITS, default 5, instruction register width (5..8).
REQ-003 SHALL have parameter IDCODE_VALUE, default 32'h1e200a6f, value captured for IDCODE; bit 0 forced to 1.
REQ-004 SHALL have parameter IDLE_CYCLES, default 3, value reported in dtmcs.idle (3 bits).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on dmi_req_ack_i and dmi_resp_i (2..4).
REQ-006 SHALL have port jtag_tck_i, input, 1, TAP clock; all state on its posedge except TDO and IR update (negedge).
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports jtag_tms_i and jtag_tdi_i, input, 1 each, TAP mode select and serial data in.
REQ-009 SHALL have ports jtag_tdo_o and jtag_tdo_oe_o, output, 1 each, serial data out and its enable.
REQ-010 SHALL have ports dmi_req_o (output, 1), dmi_req_data_o (output, DMI_ADDR_BITS+34, {addr,data[31:0],op[1:0]}) and dmi_req_ack_i (input, 1): request 4-phase handshake.
REQ-011 SHALL have ports dmi_resp_i (input, 1), dmi_resp_data_i (input, DMI_ADDR_BITS+34, same layout) and dmi_resp_ack_o (output, 1): response 4-phase handshake.
REQ-012 SHALL have port dm_hardreset_o, output, 1, one-TCK pulse requesting DM reset (only with JTAG_DTM_HARDRESET_EN).

Function
REQ-013 TAP SHALL implement all 16 IEEE 1149.1 states; 5 TCK with TMS=1 reach Test-Logic-Reset from any state.
REQ-014 Capture-IR SHALL load ...0001; Shift-IR shifts LSB first; IR SHALL update on negedge in Update-IR; Test-Logic-Reset SHALL load IDCODE (5'h01, zero-extended).
REQ-015 IR decode: 0x01 IDCODE (32 bits), 0x10 DTMCS (32 bits), 0x11 DMI (DMI_ADDR_BITS+34 bits), all others BYPASS (1 bit, capture 0).
REQ-016 DTMCS capture SHALL be {14'b0, dmihardreset=0, dmireset=0, 1'b0, IDLE_CYCLES[2:0], dmistat[1:0], DMI_ADDR_BITS[5:0], version=4'h1}.
REQ-017 dmistat SHALL be 2'b11 if sticky_busy, else 2'b10 if sticky_err, else 2'b00.
REQ-018 DTMCS Update-DR with shifted bit16=1 (dmireset) SHALL clear sticky_busy and sticky_err in that cycle.
REQ-019 DMI Capture-DR SHALL load op=2'b11, addr/data=0 if sticky_busy or a transaction is outstanding (and SHALL set sticky_busy); else op=2'b10 if sticky_err; else last response {addr,data,op}.
REQ-020 DMI Update-DR with op in {1 read, 2 write}, no sticky flag and FSM IDLE SHALL latch shift data to dmi_req_data_o and go REQ; op=0 or op=3 SHALL issue nothing; busy/sticky SHALL drop the request.
REQ-021 Request FSM: IDLE -> REQ (dmi_req_o=1) -> on synced ack=1 WAIT_ACK_LOW (dmi_req_o=0) -> on synced ack=0 WAIT_RESP -> on response latched IDLE.
REQ-022 Response: synced dmi_resp_i=1 SHALL latch dmi_resp_data_i and set dmi_resp_ack_o=1; dmi_resp_ack_o SHALL fall when synced dmi_resp_i=0.
REQ-023 Response op=2'b10 or 2'b11 SHALL set sticky_err; the latched response is still stored.
REQ-024 TDO SHALL be driven on negedge with shift_reg[0] in Shift-IR/Shift-DR, jtag_tdo_oe_o=1 only then; otherwise tdo=0, oe=0.
REQ-025 dmi_req_data_o SHALL remain stable from REQ entry until WAIT_RESP exit.

Reset
REQ-026 rst_n low SHALL force TAP Test-Logic-Reset, IR=IDCODE, FSM IDLE, sticky flags 0, stored response 0, synchronisers 0, all outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it; a late response after reset SHALL be acknowledged but not change stored data while FSM is IDLE.
REQ-028 Entering Test-Logic-Reset via TMS SHALL NOT abort an outstanding DMI transaction.

Configuration
REQ-029 With JTAG_DTM_HARDRESET_EN defined, DTMCS bit17 write SHALL clear stickies, return FSM to IDLE, drop dmi_req_o, and pulse dm_hardreset_o for one TCK.
REQ-030 Without JTAG_DTM_HARDRESET_EN, bit17 SHALL be ignored and dm_hardreset_o SHALL be tied 0.

Verification
REQ-031 Reset, 5x TMS=1, shift IDCODE DR -> 32'h1e200a6f on TDO LSB first.
REQ-032 Shift DTMCS with DMI_ADDR_BITS=7 -> 32'h00003071 (idle 3, abits 7, version 1).
REQ-033 DMI write addr 0x10 data 0x1 op 2, DM acks, response op 0 -> next DMI capture returns {0x10,0x1,0}.
REQ-034 Second DMI scan while response pending -> captured op=3, dmistat=3; dmireset write -> dmistat=0, next request issued.
REQ-035 DM returns op 2 -> dmistat=2, captures op=2 until dmireset.
REQ-036 With JTAG_DTM_HARDRESET_EN, dmihardreset mid-REQ -> dmi_req_o=0 next TCK, dm_hardreset_o one-cycle pulse.
